// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH_OP  = 2'd0,
    FETCH_IMM = 2'd1,
    EXEC      = 2'd2,
    HALTED    = 2'd3
  } fetch_state_e;

  // Opcode bit that announces a trailing immediate byte.
  localparam int IMM_BIT = 7;

  localparam logic [7:0] HALT_OP_DEFAULT = 8'h7F;

endpackage

// File: rtl/pc_counter.sv
// Program counter: async clear, synchronous load wins over count enable,
// wraps modulo 2^PC_W like a pair of cascaded 161s.
module pc_counter #(
  parameter int PC_W = 8
) (
  input  logic            clk_i,
  input  logic            clr_n_i,
  input  logic            load_i,
  input  logic [PC_W-1:0] load_val_i,
  input  logic            en_i,
  output logic [PC_W-1:0] q_o
);

  logic [PC_W-1:0] cnt_q;
  logic [PC_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i) begin
      cnt_d = cnt_q + {{(PC_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_i or negedge clr_n_i) begin
    if (!clr_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q_o = cnt_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch stage: walks the program ROM, latches opcode and optional
// immediate, and hands complete instructions to execute via ir_valid/exec_ready.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int         PC_W    = 8,
  parameter int         ROM_AW  = 11,
  parameter logic [7:0] HALT_OP = HALT_OP_DEFAULT
) (
  input  logic              CLK,
  input  logic              CLRB,
  output logic [ROM_AW-1:0] rom_a,
  output logic              rom_ceb,
  output logic              rom_oeb,
  input  logic [7:0]        rom_d,
  output logic [7:0]        ir,
  output logic [7:0]        imm,
  output logic              ir_valid,
  input  logic              exec_ready,
  input  logic              jump,
  input  logic [PC_W-1:0]   jump_addr,
  output logic [PC_W-1:0]   pc,
  output logic              halted
);

  fetch_state_e state_q, state_d;
  logic [7:0]   ir_q, ir_d;
  logic [7:0]   imm_q, imm_d;
  logic         fetching;
  logic         pc_load;

  pc_counter #(
    .PC_W(PC_W)
  ) u_pc (
    .clk_i      (CLK),
    .clr_n_i    (CLRB),
    .load_i     (pc_load),
    .load_val_i (jump_addr),
    .en_i       (fetching),
    .q_o        (pc)
  );

  always_ff @(posedge CLK or negedge CLRB) begin
    if (!CLRB) begin
      state_q <= FETCH_OP;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH_OP: begin
        if (rom_d == HALT_OP) begin
          state_d = HALTED;
        end else if (rom_d[IMM_BIT]) begin
          state_d = FETCH_IMM;
        end else begin
          state_d = EXEC;
        end
      end
      FETCH_IMM: state_d = EXEC;
      EXEC:      if (exec_ready) state_d = FETCH_OP;
      HALTED:    state_d = HALTED;
      default:   state_d = FETCH_OP;
    endcase
  end

  always_comb begin
    fetching = (state_q == FETCH_OP) || (state_q == FETCH_IMM);
    pc_load  = (state_q == EXEC) && exec_ready && jump;
    rom_ceb  = ~(fetching & CLRB);
    rom_oeb  = ~(fetching & CLRB);
    ir_valid = (state_q == EXEC);
    halted   = (state_q == HALTED);
  end

  // rom_d is only sampled in fetch states, so a floating bus elsewhere never lands here.
  always_comb begin
    ir_d  = ir_q;
    imm_d = imm_q;
    if (state_q == FETCH_OP) begin
      ir_d  = rom_d;
      imm_d = 8'h00;
    end else if (state_q == FETCH_IMM) begin
      imm_d = rom_d;
    end
  end

  always_ff @(posedge CLK or negedge CLRB) begin
    if (!CLRB) begin
      ir_q  <= 8'h00;
      imm_q <= 8'h00;
    end else begin
      ir_q  <= ir_d;
      imm_q <= imm_d;
    end
  end

  assign ir    = ir_q;
  assign imm   = imm_q;
  assign rom_a = {{(ROM_AW-PC_W){1'b0}}, pc};

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction-fetch stage sitting directly upstream of the 2048-byte program ROM (only 256 bytes used).
- Holds the program counter, drives the ROM address and enables, latches the opcode and optional immediate byte, and presents them to the execute stage through a valid/ready handshake.
- Accepts jump redirects from the execute stage.
- Functionally equivalent to a two-161 counter, a 273 instruction register, a 273 immediate register and a small control FSM.

Parameters:
- PC_W, 8, program counter width; ROM addresses above 2^PC_W-1 are never used.
- ROM_AW, 11, ROM address bus width; upper ROM_AW-PC_W bits are driven 0.
- HALT_OP, 8'h7F, opcode that stops fetching.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- CLRB  input  1  asynchronous active-low reset/clear.
- rom_a  output  ROM_AW  ROM address: {0, pc}.
- rom_ceb  output  1  ROM chip enable, active low.
- rom_oeb  output  1  ROM output enable, active low.
- rom_d  input  8  ROM data byte.
- ir  output  8  latched opcode.
- imm  output  8  latched immediate byte; 0 for 1-byte instructions.
- ir_valid  output  1  ir/imm hold a complete instruction for execute.
- exec_ready  input  1  execute consumes the instruction this cycle.
- jump  input  1  redirect the PC; sampled only on the handshake cycle.
- jump_addr  input  PC_W  jump target.
- pc  output  PC_W  current program counter, for debug and display.
- halted  output  1  HALT_OP has been fetched.

Behaviour:
- Reset (CLRB low, asynchronous, dominates the clock):
  - state=FETCH_OP, pc=0, ir=0, imm=0.
  - ir_valid=0, halted=0.
  - rom_ceb=1 and rom_oeb=1 while CLRB is low.
- ROM enables:
  - rom_ceb=rom_oeb=0 only in FETCH_OP and FETCH_IMM (CLRB high); otherwise both are 1.
  - rom_a = {(ROM_AW-PC_W)'b0, pc} in every state.
- FETCH_OP, on the clock edge:
  - ir<=rom_d, imm<=0, pc<=pc+1.
  - rom_d==HALT_OP -> HALTED.
  - else rom_d[7]==1 (immediate follows) -> FETCH_IMM.
  - else -> EXEC.
- FETCH_IMM, on the clock edge: imm<=rom_d, pc<=pc+1, -> EXEC.
- EXEC:
  - ir_valid=1 (decoded combinationally from state); ir/imm stable.
  - Edge with exec_ready=1: pc<=jump ? jump_addr : pc, -> FETCH_OP.
  - Edge with exec_ready=0: hold everything; jump is ignored.
- HALTED:
  - ir_valid=0, halted=1, ROM disabled, pc frozen at the address after the HALT byte.
  - Exit only via CLRB.
- PC arithmetic: modulo 2^PC_W; 8'hFF+1 -> 8'h00. An opcode at 8'hFF with an immediate takes the immediate from address 8'h00.
- Throughput: a 1-byte instruction takes 2 cycles (FETCH_OP, EXEC); a 2-byte instruction takes 3 cycles, both with exec_ready held high. A stall adds one cycle per exec_ready-low cycle.
- A jump to the current pc is legal and simply refetches.
- exec_ready and jump outside EXEC have no effect.
- Reset asserted mid-fetch or mid-EXEC aborts immediately: the in-flight instruction is dropped and all outputs take their reset values.
- rom_d X/Z outside fetch states must not propagate into any register.

Decomposition:
- Package fetch_pkg:
  - state enum {FETCH_OP, FETCH_IMM, EXEC, HALTED}.
  - IMM_BIT=7.
  - Default HALT_OP constant.
- One sub-module, pc_counter: PC_W-bit counter with async active-low clear, synchronous load (jump) and count enable, mirroring two cascaded 161s.
- FSM, instruction register and immediate register live in fetch_sequencer.

Test Plan:
- Reset then ROM[0]=8'h01, ROM[1]=8'h02, exec_ready=1 -> ir=01 valid in cycle 2, ir=02 valid in cycle 4, imm=0 both times; pc sequence 0,1,1,2,2.
- ROM[0]=8'h85, ROM[1]=8'hAA, ROM[2]=8'h03 -> ir=85/imm=AA valid at cycle 3 with pc=2; next instruction ir=03, imm=00.
- exec_ready=0 for 5 cycles in EXEC, jump=1 pulsed during the stall -> ir/imm/pc unchanged and the jump is ignored; then ready=1, jump=1, jump_addr=8'h40 -> next rom_a=11'h040.
- Execution runs sequentially to 8'hFF holding 8'h90, with ROM[0]=8'h11 -> imm=11, pc wraps to 8'h01.
- ROM[3]=8'h7F -> halted=1, ir_valid=0, rom_ceb=rom_oeb=1, pc=4 frozen for 20 cycles; CLRB pulse -> pc=0, halted=0.
- CLRB asserted asynchronously mid-FETCH_IMM (between clock edges) -> ir=imm=0, pc=0, ir_valid=0 without waiting for CLK; fetching restarts at address 0 after release.
